// File: rtl/dadda_pipe_mul.sv
// Pipelined unsigned Dadda-tree multiplier with valid/ready handshake, two register stages, optional low-column approximation.
// Optional mean-error compensation of the approximate product is enabled by defining DADDA_APPROX_COMP_EN.
module dadda_pipe_mul #(
   parameter int WIDTH       = 8,
   parameter int OUT_WIDTH   = 2*WIDTH,
   parameter int APPROX_COLS = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in1,
   input  logic [WIDTH-1:0]     in2,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [OUT_WIDTH-1:0] out_prod,
   output logic                 out_overflow
);

   localparam int PW       = 2*WIDTH;
   localparam int NLVL     = $clog2(PW);
   localparam int COMP_BIT = (APPROX_COLS > 0) ? APPROX_COLS-1 : 0;
`ifdef DADDA_APPROX_COMP_EN
   localparam logic [PW-1:0] COMP_MASK = (APPROX_COLS > 0) ? (PW'(1) << COMP_BIT) : '0;
`else
   localparam logic [PW-1:0] COMP_MASK = '0;
`endif

   function automatic int dseq(input int s);
      case (s)
         0:       return 2;
         1:       return 3;
         2:       return 4;
         3:       return 6;
         4:       return 9;
         5:       return 13;
         6:       return 19;
         default: return 28;
      endcase
   endfunction

   // ---------------- Dadda reduction (combinational) ----------------
   logic [WIDTH-1:0] col_c [PW];
   logic [WIDTH-1:0] col_n [PW];
   int               h_c   [PW];
   int               h_n   [PW];
   int               cur, p, d;
   logic             cell_s, cell_c;
   logic [PW-1:0]    red_a, red_b;

   always_comb begin
      cur    = 0;
      p      = 0;
      d      = 0;
      cell_s = 1'b0;
      cell_c = 1'b0;
      red_a  = '0;
      red_b  = '0;
      for (int c = 0; c < PW; c++) begin
         col_c[c] = '0;
         col_n[c] = '0;
         h_c[c]   = 0;
         h_n[c]   = 0;
      end
      // Discarded partial products keep their slot as a constant 0 so the tree shape is unchanged.
      for (int i = 0; i < WIDTH; i++) begin
         for (int j = 0; j < WIDTH; j++) begin
            if (i + j >= APPROX_COLS)
               col_c[i+j][h_c[i+j]] = in1[j] & in2[i];
            h_c[i+j] = h_c[i+j] + 1;
         end
      end
      for (int s = 7; s >= 0; s--) begin
         if (dseq(s) < WIDTH) begin
            d = dseq(s);
            for (int c = 0; c < PW; c++) begin
               col_n[c] = '0;
               h_n[c]   = 0;
            end
            for (int c = 0; c < PW; c++) begin
               // Carries arriving from column c-1 in this stage already count toward the height.
               cur = h_c[c] + h_n[c];
               p   = 0;
               for (int k = 0; k < WIDTH; k++) begin
                  if (cur > d) begin
                     if (cur - d >= 2) begin
                        cell_s = col_c[c][p] ^ col_c[c][p+1] ^ col_c[c][p+2];
                        cell_c = (col_c[c][p] & col_c[c][p+1]) |
                                 (col_c[c][p+2] & (col_c[c][p] ^ col_c[c][p+1]));
                        p   = p + 3;
                        cur = cur - 2;
                     end else begin
                        cell_s = col_c[c][p] ^ col_c[c][p+1];
                        cell_c = col_c[c][p] & col_c[c][p+1];
                        p   = p + 2;
                        cur = cur - 1;
                     end
                     col_n[c][h_n[c]] = cell_s;
                     h_n[c] = h_n[c] + 1;
                     if (c + 1 < PW) begin
                        col_n[c+1][h_n[c+1]] = cell_c;
                        h_n[c+1] = h_n[c+1] + 1;
                     end
                  end
               end
               for (int k = 0; k < WIDTH; k++) begin
                  if (k >= p && k < h_c[c]) begin
                     col_n[c][h_n[c]] = col_c[c][k];
                     h_n[c] = h_n[c] + 1;
                  end
               end
            end
            for (int c = 0; c < PW; c++) begin
               col_c[c] = col_n[c];
               h_c[c]   = h_n[c];
            end
         end
      end
      for (int c = 0; c < PW; c++) begin
         if (h_c[c] > 0) red_a[c] = col_c[c][0];
         if (h_c[c] > 1) red_b[c] = col_c[c][1];
      end
   end

   // ---------------- Handshake and stage registers ----------------
   logic                 s1_valid_q, s1_valid_d;
   logic                 s2_valid_q, s2_valid_d;
   logic [PW-1:0]        row_a_q, row_a_d;
   logic [PW-1:0]        row_b_q, row_b_d;
   logic [OUT_WIDTH-1:0] prod_q, prod_d;
   logic                 ovf_q, ovf_d;
   logic                 s1_adv, s2_adv;

   // ---------------- Kogge-Stone final adder on the S1 rows ----------------
   logic [PW-1:0] ks_g, ks_p, ks_gn, ks_pn, ks_hx, sum_raw, sum_cmp;
   logic          sum_ovf;

   always_comb begin
      ks_hx = row_a_q ^ row_b_q;
      ks_g  = row_a_q & row_b_q;
      ks_p  = ks_hx;
      ks_gn = '0;
      ks_pn = '0;
      for (int l = 0; l < NLVL; l++) begin
         ks_gn = ks_g;
         ks_pn = ks_p;
         for (int i = 0; i < PW; i++) begin
            if (i >= (1 << l)) begin
               ks_gn[i] = ks_g[i] | (ks_p[i] & ks_g[i-(1<<l)]);
               ks_pn[i] = ks_p[i] & ks_p[i-(1<<l)];
            end
         end
         ks_g = ks_gn;
         ks_p = ks_pn;
      end
      sum_raw = ks_hx ^ {ks_g[PW-2:0], 1'b0};
      sum_cmp = sum_raw | COMP_MASK;
   end

   generate
      if (OUT_WIDTH < PW) begin : g_ovf
         assign sum_ovf = |sum_cmp[PW-1:OUT_WIDTH];
      end else begin : g_no_ovf
         assign sum_ovf = 1'b0;
      end
   endgenerate

   always_comb begin
      s2_adv     = !s2_valid_q | out_ready;
      s1_adv     = !s1_valid_q | s2_adv;
      in_ready   = s1_adv;
      s1_valid_d = s1_adv ? in_valid : s1_valid_q;
      s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;
      row_a_d    = row_a_q;
      row_b_d    = row_b_q;
      prod_d     = prod_q;
      ovf_d      = ovf_q;
      if (s1_adv && in_valid) begin
         row_a_d = red_a;
         row_b_d = red_b;
      end
      // Output registers load only on a real result so out_prod holds its last value when idle.
      if (s2_adv && s1_valid_q) begin
         prod_d = sum_cmp[OUT_WIDTH-1:0];
         ovf_d  = sum_ovf;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
         row_a_q    <= '0;
         row_b_q    <= '0;
         prod_q     <= '0;
         ovf_q      <= 1'b0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s2_valid_q <= s2_valid_d;
         row_a_q    <= row_a_d;
         row_b_q    <= row_b_d;
         prod_q     <= prod_d;
         ovf_q      <= ovf_d;
      end
   end

   assign out_valid    = s2_valid_q;
   assign out_prod     = prod_q;
   assign out_overflow = ovf_q;

endmodule

// File: tb/tb_dadda_pipe_mul.sv
// Bench for dadda_pipe_mul: exact, truncated (OUT_WIDTH=8) and approximate (APPROX_COLS=4) instances share one stimulus.
module tb_dadda_pipe_mul;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n     = 1'b0;
   logic       in_valid  = 1'b0;
   logic       out_ready = 1'b1;
   logic [7:0] in1       = 8'h00;
   logic [7:0] in2       = 8'h00;

   logic        e_in_ready, e_out_valid, e_ovf;
   logic [15:0] e_prod;
   logic        t_in_ready, t_out_valid, t_ovf;
   logic [7:0]  t_prod;
   logic        a_in_ready, a_out_valid, a_ovf;
   logic [15:0] a_prod;

   dadda_pipe_mul #(.WIDTH(8), .OUT_WIDTH(16), .APPROX_COLS(0)) u_exact (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(e_in_ready),
      .in1(in1), .in2(in2), .out_valid(e_out_valid), .out_ready(out_ready),
      .out_prod(e_prod), .out_overflow(e_ovf));

   dadda_pipe_mul #(.WIDTH(8), .OUT_WIDTH(8), .APPROX_COLS(0)) u_trunc (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(t_in_ready),
      .in1(in1), .in2(in2), .out_valid(t_out_valid), .out_ready(out_ready),
      .out_prod(t_prod), .out_overflow(t_ovf));

   dadda_pipe_mul #(.WIDTH(8), .OUT_WIDTH(16), .APPROX_COLS(4)) u_approx (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
      .in1(in1), .in2(in2), .out_valid(a_out_valid), .out_ready(out_ready),
      .out_prod(a_prod), .out_overflow(a_ovf));

`ifdef DADDA_APPROX_COMP_EN
   localparam logic [15:0] COMP = 16'h0008;
`else
   localparam logic [15:0] COMP = 16'h0000;
`endif

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [7:0]  a;
      logic [7:0]  b;
      logic [15:0] exact;
      logic [7:0]  trunc;
      logic        tovf;
      logic [15:0] approx;
   } vec_t;

   vec_t        vecs [8];
   logic [15:0] s_exp [3];

   initial begin
      // {a, b, exact, truncated low byte, truncated overflow, approx before compensation}
      vecs[0] = '{8'hFF, 8'hFF, 16'hFE01, 8'h01, 1'b1, 16'hFDD0};
      vecs[1] = '{8'h00, 8'hA5, 16'h0000, 8'h00, 1'b0, 16'h0000};
      vecs[2] = '{8'h10, 8'h10, 16'h0100, 8'h00, 1'b1, 16'h0100};
      vecs[3] = '{8'h0F, 8'h11, 16'h00FF, 8'hFF, 1'b0, 16'h00F0};
      vecs[4] = '{8'h01, 8'h01, 16'h0001, 8'h01, 1'b0, 16'h0000};
      vecs[5] = '{8'h03, 8'h05, 16'h000F, 8'h0F, 1'b0, 16'h0000};
      vecs[6] = '{8'hAB, 8'hCD, 16'h88EF, 8'hEF, 1'b1, 16'h88D0};
      vecs[7] = '{8'h80, 8'h02, 16'h0100, 8'h00, 1'b1, 16'h0100};
      s_exp[0] = 16'd15;
      s_exp[1] = 16'd63;
      s_exp[2] = 16'd510;

      // Reset state
      #12;
      chk("rst out_valid", 32'(e_out_valid), 32'h0);
      chk("rst out_prod", 32'(e_prod), 32'h0);
      chk("rst out_overflow", 32'(e_ovf), 32'h0);
      chk("rst trunc out_prod", 32'(t_prod), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("post-rst in_ready", 32'(e_in_ready), 32'h1);

      // Single-shot vectors: result appears after the second edge, not the first
      for (int n = 0; n < 8; n++) begin
         @(negedge clk);
         in_valid = 1'b1;
         in1 = vecs[n].a;
         in2 = vecs[n].b;
         chk($sformatf("vec%0d in_ready", n), 32'(e_in_ready), 32'h1);
         @(posedge clk);
         #1;
         in_valid = 1'b0;
         chk($sformatf("vec%0d early out_valid", n), 32'(e_out_valid), 32'h0);
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d out_valid", n), 32'(e_out_valid), 32'h1);
         chk($sformatf("vec%0d exact", n), 32'(e_prod), 32'(vecs[n].exact));
         chk($sformatf("vec%0d exact ovf", n), 32'(e_ovf), 32'h0);
         chk($sformatf("vec%0d trunc", n), 32'(t_prod), 32'(vecs[n].trunc));
         chk($sformatf("vec%0d trunc ovf", n), 32'(t_ovf), 32'(vecs[n].tovf));
         chk($sformatf("vec%0d approx", n), 32'(a_prod), 32'(vecs[n].approx | COMP));
      end
      repeat (2) @(negedge clk);

      // Back-to-back streaming
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (k == 0) begin in1 = 8'd3;   in2 = 8'd5; end
         if (k == 1) begin in1 = 8'd7;   in2 = 8'd9; end
         if (k == 2) begin in1 = 8'd255; in2 = 8'd2; end
         in_valid = (k < 3);
         if (k < 3) chk($sformatf("stream%0d in_ready", k), 32'(e_in_ready), 32'h1);
         @(posedge clk);
         #1;
         if (k >= 1) begin
            chk($sformatf("stream%0d out_valid", k), 32'(e_out_valid), 32'h1);
            chk($sformatf("stream%0d prod", k), 32'(e_prod), 32'(s_exp[k-1]));
         end
      end
      @(posedge clk);
      #1;
      chk("stream drained", 32'(e_out_valid), 32'h0);

      // Backpressure: capacity two, third refused until the first pops
      @(negedge clk);
      out_ready = 1'b0;
      in_valid = 1'b1; in1 = 8'd2; in2 = 8'd3;
      chk("bp p0 in_ready", 32'(e_in_ready), 32'h1);
      @(negedge clk);
      in1 = 8'd4; in2 = 8'd5;
      chk("bp p1 in_ready", 32'(e_in_ready), 32'h1);
      @(negedge clk);
      in1 = 8'd6; in2 = 8'd7;
      chk("bp p2 refused", 32'(e_in_ready), 32'h0);
      chk("bp hold prod", 32'(e_prod), 32'd6);
      @(negedge clk);
      chk("bp still refused", 32'(e_in_ready), 32'h0);
      chk("bp stable prod", 32'(e_prod), 32'd6);
      chk("bp stable valid", 32'(e_out_valid), 32'h1);
      out_ready = 1'b1;
      #1;
      chk("bp release in_ready", 32'(e_in_ready), 32'h1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("bp drain 1", 32'(e_prod), 32'd20);
      @(posedge clk);
      #1;
      chk("bp drain 2", 32'(e_prod), 32'd42);
      chk("bp drain 2 valid", 32'(e_out_valid), 32'h1);
      @(posedge clk);
      #1;
      chk("bp empty", 32'(e_out_valid), 32'h0);

      // Asynchronous reset with two results buffered
      @(negedge clk);
      out_ready = 1'b0;
      in_valid = 1'b1; in1 = 8'd9; in2 = 8'd9;
      @(negedge clk);
      in1 = 8'd10; in2 = 8'd10;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("rst-mid buffered prod", 32'(e_prod), 32'd81);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst-mid out_valid", 32'(e_out_valid), 32'h0);
      chk("rst-mid out_prod", 32'(e_prod), 32'h0);
      chk("rst-mid approx prod", 32'(a_prod), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk);
         #1;
         chk($sformatf("rst-mid quiet%0d", k), 32'(e_out_valid), 32'h0);
      end
      chk("rst-mid in_ready", 32'(e_in_ready), 32'h1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
